// File: rtl/paint_scheduler.sv
// paint_scheduler: owns the box painter port and time-shares it between the
// board clear sweep, atomic piece moves (erase then draw) and single-cell
// repaints. Converts cell coordinates to pixel origins, one box in flight.
module paint_scheduler #(
  parameter int unsigned COLS           = 10,
  parameter int unsigned ROWS           = 20,
  parameter logic [8:0]  BG_COLOR       = 9'h000,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] DONE_TIMEOUT   = 16'hFFFF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       clr_req,
  input  logic       mv_req,
  input  logic [3:0] mv_old_x,
  input  logic [4:0] mv_old_y,
  input  logic [3:0] mv_new_x,
  input  logic [4:0] mv_new_y,
  input  logic [8:0] mv_color,
  output logic       mv_ack,
  input  logic       cell_req,
  input  logic [3:0] cell_x,
  input  logic [4:0] cell_y,
  input  logic [8:0] cell_color,
  output logic       cell_ack,
  output logic       err,
  output logic       clearing,
  output logic       kick,
  output logic [9:0] x0,
  output logic [8:0] y0,
  output logic [8:0] paint_color,
  input  logic       pnt_done,
  input  logic       pnt_busy
);

  localparam logic [3:0] X_LAST = 4'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  typedef enum logic [3:0] {
    IDLE, CLR_ISSUE, CLR_WAIT, ER_ISSUE, ER_WAIT,
    DR_ISSUE, DR_WAIT, CL_ISSUE, CL_WAIT
  } state_t;

  state_t      state_q;
  logic        clr_pending_q;
  logic        clr_restart_q;
  logic [3:0]  cx_q;
  logic [4:0]  cy_q;
  logic [15:0] tmo_q;

  // Pixel origin of a cell: x*64 and y*24 (y*16 + y*8).
  function automatic logic [9:0] px(input logic [3:0] x);
    return {x, 6'b000000};
  endfunction

  function automatic logic [8:0] py(input logic [4:0] y);
    return {y, 4'b0000} + 9'({y, 3'b000});
  endfunction

  // Handshake and range helpers shared by every state.
  logic issue_ok_c, tmo_hit_c, box_end_c, mv_bad_c, cell_bad_c;
  assign issue_ok_c = !pnt_busy && !kick;
  assign tmo_hit_c  = (tmo_q == DONE_TIMEOUT - 16'd1);
  assign box_end_c  = pnt_done || tmo_hit_c;
  assign mv_bad_c   = (mv_old_x > X_LAST) || (mv_old_y > Y_LAST) ||
                      (mv_new_x > X_LAST) || (mv_new_y > Y_LAST);
  assign cell_bad_c = (cell_x > X_LAST) || (cell_y > Y_LAST);

  // Scheduler FSM with registered painter interface and acks.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      clr_pending_q <= CLEAR_ON_RESET;
      clearing      <= CLEAR_ON_RESET;
      clr_restart_q <= 1'b0;
      cx_q          <= 4'd0;
      cy_q          <= 5'd0;
      tmo_q         <= 16'd0;
      kick          <= 1'b0;
      mv_ack        <= 1'b0;
      cell_ack      <= 1'b0;
      err           <= 1'b0;
      x0            <= 10'd0;
      y0            <= 9'd0;
      paint_color   <= 9'd0;
    end else begin
      kick     <= 1'b0;
      mv_ack   <= 1'b0;
      cell_ack <= 1'b0;
      err      <= 1'b0;

      if (clr_req) begin
        clr_pending_q <= 1'b1;
        clearing      <= 1'b1;
        if (state_q == CLR_ISSUE || state_q == CLR_WAIT) clr_restart_q <= 1'b1;
      end

      if (state_q == CLR_WAIT || state_q == ER_WAIT ||
          state_q == DR_WAIT  || state_q == CL_WAIT) begin
        if (box_end_c) err <= !pnt_done;
        else           tmo_q <= tmo_q + 16'd1;
      end

      case (state_q)
        IDLE: begin
          // A requester is not re-granted on its own ack cycle.
          if (clr_pending_q || clr_req) begin
            state_q       <= CLR_ISSUE;
            clr_restart_q <= 1'b0;
            cx_q          <= 4'd0;
            cy_q          <= 5'd0;
          end else if (mv_req && !mv_ack) begin
            if (mv_bad_c) begin
              mv_ack <= 1'b1;
              err    <= 1'b1;
            end else begin
              state_q <= ER_ISSUE;
            end
          end else if (cell_req && !cell_ack) begin
            if (cell_bad_c) begin
              cell_ack <= 1'b1;
              err      <= 1'b1;
            end else begin
              state_q <= CL_ISSUE;
            end
          end
        end
        CLR_ISSUE: if (issue_ok_c) begin
          x0 <= px(cx_q); y0 <= py(cy_q); paint_color <= BG_COLOR;
          kick <= 1'b1; tmo_q <= 16'd0; state_q <= CLR_WAIT;
        end
        CLR_WAIT: if (box_end_c) begin
          state_q <= CLR_ISSUE;
          if (clr_restart_q || clr_req) begin
            cx_q          <= 4'd0;
            cy_q          <= 5'd0;
            clr_restart_q <= 1'b0;
          end else if (cx_q == X_LAST) begin
            cx_q <= 4'd0;
            if (cy_q == Y_LAST) begin
              cy_q          <= 5'd0;
              clr_pending_q <= 1'b0;
              clearing      <= 1'b0;
              state_q       <= IDLE;
            end else begin
              cy_q <= cy_q + 5'd1;
            end
          end else begin
            cx_q <= cx_q + 4'd1;
          end
        end
        ER_ISSUE: if (issue_ok_c) begin
          x0 <= px(mv_old_x); y0 <= py(mv_old_y); paint_color <= BG_COLOR;
          kick <= 1'b1; tmo_q <= 16'd0; state_q <= ER_WAIT;
        end
        ER_WAIT: if (box_end_c) state_q <= DR_ISSUE;
        DR_ISSUE: if (issue_ok_c) begin
          x0 <= px(mv_new_x); y0 <= py(mv_new_y); paint_color <= mv_color;
          kick <= 1'b1; tmo_q <= 16'd0; state_q <= DR_WAIT;
        end
        DR_WAIT: if (box_end_c) begin
          mv_ack  <= 1'b1;
          state_q <= IDLE;
        end
        CL_ISSUE: if (issue_ok_c) begin
          x0 <= px(cell_x); y0 <= py(cell_y); paint_color <= cell_color;
          kick <= 1'b1; tmo_q <= 16'd0; state_q <= CL_WAIT;
        end
        CL_WAIT: if (box_end_c) begin
          cell_ack <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
